text_wr_ctrl: RTL and testbench

TEXT_WR_CTRL -- requirements
Module: text_wr_ctrl

---
 rtl/text_wr_ctrl.sv | 211 +++++++++++++++++++++
 tb/tb_text_wr_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_wr_ctrl.sv
// Text-mode RAM write controller: UART bytes and keys become text RAM writes, plus a full-screen clear.
// Optional macro TEXT_CTRL_CHAR_EN makes 0x0D/0x0A/0x08 move the cursor instead of being written.
`timescale 1ns/1ps
module text_wr_ctrl #(
  parameter int unsigned COLS      = 80,
  parameter int unsigned ROWS      = 30,
  parameter logic [7:0]  FILL_CHAR = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_tick,
  input  logic [7:0]  rx_data,
  input  logic        key_right,
  input  logic        key_down,
  input  logic        key_wr,
  input  logic        clr_req,
  output logic        we,
  output logic [11:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic [6:0]  cur_x,
  output logic [4:0]  cur_y,
  output logic        busy,
  output logic        rx_ovf
);

  localparam logic [6:0] X_MAX = 7'(COLS - 1);
  localparam logic [4:0] Y_MAX = 5'(ROWS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [6:0]  r_x, w_x_nxt;
  logic [4:0]  r_y, w_y_nxt;
  logic [6:0]  r_clr_x, w_clr_x_nxt;
  logic [4:0]  r_clr_y, w_clr_y_nxt;
  logic        r_clr_end, w_clr_end_nxt;
  logic        r_we, w_we_nxt;
  logic [11:0] r_addr, w_addr_nxt;
  logic [7:0]  r_data, w_data_nxt;
  logic        r_hold_vld, w_hold_vld_nxt;
  logic [7:0]  r_hold_data, w_hold_data_nxt;
  logic        r_ovf, w_ovf_nxt;
  logic [7:0]  r_last, w_last_nxt;

  logic        w_rx_vld;
  logic [7:0]  w_rx_byte;
  logic        w_is_ctrl;
  logic [11:0] w_cur_step;
  logic [11:0] w_clr_step;
  logic [11:0] w_first_step;

  // Row-major successor of a screen position, wrapping to (0,0) after the last tile.
  function automatic logic [11:0] step_pos(input logic [6:0] x, input logic [4:0] y);
    logic [6:0] nx;
    logic [4:0] ny;
    if (x == X_MAX) begin
      nx = 7'd0;
      ny = (y == Y_MAX) ? 5'd0 : y + 5'd1;
    end else begin
      nx = x + 7'd1;
      ny = y;
    end
    return {ny, nx};
  endfunction

  assign w_cur_step   = step_pos(r_x, r_y);
  assign w_clr_step   = step_pos(r_clr_x, r_clr_y);
  assign w_first_step = step_pos(7'd0, 5'd0);

  // A byte parked during a clear is older than any new tick, so it is served first.
  assign w_rx_vld  = r_hold_vld | rx_tick;
  assign w_rx_byte = r_hold_vld ? r_hold_data : rx_data;

`ifdef TEXT_CTRL_CHAR_EN
  assign w_is_ctrl = (w_rx_byte == 8'h0D) || (w_rx_byte == 8'h0A) || (w_rx_byte == 8'h08);
`else
  assign w_is_ctrl = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x         <= 7'd0;
      r_y         <= 5'd0;
      r_clr_x     <= 7'd0;
      r_clr_y     <= 5'd0;
      r_clr_end   <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= 12'd0;
      r_data      <= 8'd0;
      r_hold_vld  <= 1'b0;
      r_hold_data <= 8'd0;
      r_ovf       <= 1'b0;
      r_last      <= 8'h20;
    end else begin
      r_state     <= w_state_nxt;
      r_x         <= w_x_nxt;
      r_y         <= w_y_nxt;
      r_clr_x     <= w_clr_x_nxt;
      r_clr_y     <= w_clr_y_nxt;
      r_clr_end   <= w_clr_end_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_hold_vld  <= w_hold_vld_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_ovf       <= w_ovf_nxt;
      r_last      <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (clr_req) w_state_nxt = S_CLEAR;
      S_CLEAR: if (r_clr_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_x_nxt         = r_x;
    w_y_nxt         = r_y;
    w_clr_x_nxt     = r_clr_x;
    w_clr_y_nxt     = r_clr_y;
    w_clr_end_nxt   = r_clr_end;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_hold_vld_nxt  = r_hold_vld;
    w_hold_data_nxt = r_hold_data;
    w_ovf_nxt       = r_ovf;
    w_last_nxt      = r_last;

    case (r_state)
      S_IDLE: begin
        if (clr_req) begin
          // The first fill write leaves with the request so busy and we line up.
          w_we_nxt      = 1'b1;
          w_addr_nxt    = 12'd0;
          w_data_nxt    = FILL_CHAR;
          w_clr_x_nxt   = w_first_step[6:0];
          w_clr_y_nxt   = w_first_step[11:7];
          w_clr_end_nxt = (X_MAX == 7'd0) && (Y_MAX == 5'd0);
        end else if (w_rx_vld) begin
          if (r_hold_vld) begin
            w_hold_vld_nxt = rx_tick;
            if (rx_tick) w_hold_data_nxt = rx_data;
          end
          if (w_is_ctrl) begin
            case (w_rx_byte)
              8'h0D:   w_x_nxt = 7'd0;
              8'h0A:   w_y_nxt = (r_y == Y_MAX) ? 5'd0 : r_y + 5'd1;
              default: w_x_nxt = (r_x == 7'd0) ? 7'd0 : r_x - 7'd1;
            endcase
          end else begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = {r_y, r_x};
            w_data_nxt = w_rx_byte;
            w_last_nxt = w_rx_byte;
            w_x_nxt    = w_cur_step[6:0];
            w_y_nxt    = w_cur_step[11:7];
          end
        end else begin
          if (key_wr) begin
            w_we_nxt   = 1'b1;
            w_addr_nxt = {r_y, r_x};
            w_data_nxt = r_last;
          end
          if (key_right) w_x_nxt = (r_x == X_MAX) ? 7'd0 : r_x + 7'd1;
          if (key_down)  w_y_nxt = (r_y == Y_MAX) ? 5'd0 : r_y + 5'd1;
        end
      end

      S_CLEAR: begin
        if (rx_tick) begin
          w_hold_vld_nxt  = 1'b1;
          w_hold_data_nxt = rx_data;
          if (r_hold_vld) w_ovf_nxt = 1'b1;
        end
        if (!r_clr_end) begin
          w_we_nxt   = 1'b1;
          w_addr_nxt = {r_clr_y, r_clr_x};
          w_data_nxt = FILL_CHAR;
          if ((r_clr_x == X_MAX) && (r_clr_y == Y_MAX)) begin
            w_clr_end_nxt = 1'b1;
          end else begin
            w_clr_x_nxt = w_clr_step[6:0];
            w_clr_y_nxt = w_clr_step[11:7];
          end
        end else begin
          w_x_nxt       = 7'd0;
          w_y_nxt       = 5'd0;
          w_clr_end_nxt = 1'b0;
        end
      end

      default: ;
    endcase
  end

  assign we      = r_we;
  assign wr_addr = r_addr;
  assign wr_data = r_data;
  assign cur_x   = r_x;
  assign cur_y   = r_y;
  assign busy    = (r_state == S_CLEAR);
  assign rx_ovf  = r_ovf;

endmodule

// File: tb/tb_text_wr_ctrl.sv
// Bench for text_wr_ctrl: vector table plus hand sequences, writes checked through an expected-write queue.
`timescale 1ns/1ps
module tb_text_wr_ctrl;

  typedef struct {
    logic [11:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic        rxTick;
    logic [7:0]  rxData;
    logic        keyRight;
    logic        keyDown;
    logic        keyWr;
    logic        expWe;
    logic [11:0] expAddr;
    logic [7:0]  expData;
    logic [6:0]  expX;
    logic [4:0]  expY;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        rx_tick = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        key_right = 1'b0;
  logic        key_down = 1'b0;
  logic        key_wr = 1'b0;
  logic        clr_req = 1'b0;
  logic        we;
  logic [11:0] wr_addr;
  logic [7:0]  wr_data;
  logic [6:0]  cur_x;
  logic [4:0]  cur_y;
  logic        busy;
  logic        rx_ovf;

  int  total = 0;
  int  bad = 0;
  int  wrCount = 0;
  bit  sbEnable = 1'b1;
  wr_t expQ[$];
  vec_t tbl[10];

  text_wr_ctrl dut (
    .clk(clk), .rst_n(rst_n), .rx_tick(rx_tick), .rx_data(rx_data),
    .key_right(key_right), .key_down(key_down), .key_wr(key_wr), .clr_req(clr_req),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .cur_x(cur_x), .cur_y(cur_y),
    .busy(busy), .rx_ovf(rx_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] addrOf(input int x, input int y);
    return 12'(y * 128 + x);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Every RAM write must match the oldest expected write, in order.
  always @(negedge clk) begin
    if (rst_n && we) begin
      wr_t e;
      wrCount++;
      if (sbEnable) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_write_addr", {20'd0, wr_addr}, 32'hFFFF_FFFF);
        end else begin
          e = expQ.pop_front();
          checkOutput("wr_addr", {20'd0, wr_addr}, {20'd0, e.addr});
          checkOutput("wr_data", {24'd0, wr_data}, {24'd0, e.data});
        end
      end
    end
  end

  task automatic applyStimulus(input logic rt, input logic [7:0] rd, input logic kr,
                               input logic kd, input logic kw, input logic cr);
    rx_tick = rt; rx_data = rd; key_right = kr; key_down = kd; key_wr = kw; clr_req = cr;
    @(posedge clk); #1;
    rx_tick = 1'b0; rx_data = 8'h00; key_right = 1'b0; key_down = 1'b0; key_wr = 1'b0; clr_req = 1'b0;
  endtask

  task automatic stepIdle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic rxWrite(input logic [7:0] d, input int x, input int y);
    expQ.push_back('{addrOf(x, y), d});
    applyStimulus(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic moveBy(input int dx, input int dy);
    for (int i = 0; i < dx; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < dy; i++) applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic checkCursor(input string name, input int x, input int y);
    checkOutput({name, "_x"}, {25'd0, cur_x}, 32'(x));
    checkOutput({name, "_y"}, {27'd0, cur_y}, 32'(y));
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    #2;
    checkOutput("rst_we", {31'd0, we}, 32'd0);
    checkOutput("rst_addr", {20'd0, wr_addr}, 32'd0);
    checkOutput("rst_data", {24'd0, wr_data}, 32'd0);
    checkCursor("rst_cur", 0, 0);
    checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_ovf", {31'd0, rx_ovf}, 32'd0);
    @(negedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic checkQueueEmpty(input string name);
    stepIdle(2);
    checkOutput(name, 32'(expQ.size()), 32'd0);
  endtask

  // Full-screen clear; optionally two rx bytes arrive mid-clear, otherwise ignored inputs are poked.
  task automatic runClear(input bit withRx);
    int cyc;
    int startCnt;
    for (int y = 0; y < 30; y++)
      for (int x = 0; x < 80; x++)
        expQ.push_back('{addrOf(x, y), 8'h00});
    startCnt = wrCount;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("busy_after_clr", {31'd0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 3000) begin
      if (withRx && cyc == 10) begin
        applyStimulus(1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ovf_after_first_rx", {31'd0, rx_ovf}, 32'd0);
      end else if (withRx && cyc == 20) begin
        applyStimulus(1'b1, 8'h32, 1'b0, 1'b0, 1'b0, 1'b0);
        expQ.push_back('{addrOf(0, 0), 8'h32});
        checkOutput("ovf_after_second_rx", {31'd0, rx_ovf}, 32'd1);
      end else if (!withRx && cyc == 100) begin
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1);
      end else begin
        stepIdle(1);
      end
      cyc++;
    end
    checkOutput("clear_within_budget", 32'(cyc < 3000), 32'd1);
    checkOutput("clear_we_count", 32'(wrCount - startCnt), 32'd2400);
    checkCursor("cur_after_clear", 0, 0);
    stepIdle(3);
    if (withRx) begin
      checkOutput("we_count_with_hold", 32'(wrCount - startCnt), 32'd2401);
      checkCursor("cur_after_hold", 1, 0);
      checkOutput("ovf_sticky", {31'd0, rx_ovf}, 32'd1);
    end else begin
      checkOutput("we_count_no_extra", 32'(wrCount - startCnt), 32'd2400);
      checkOutput("busy_low", {31'd0, busy}, 32'd0);
    end
    checkQueueEmpty(withRx ? "queue_after_clear_rx" : "queue_after_clear");
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cnt;
    //          rx   data   rt   dn   kw   we   addr            data   x     y
    tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, addrOf(0, 0), 8'h20, 7'd0, 5'd0};
    tbl[1] = '{1'b1, 8'h41, 1'b0, 1'b0, 1'b0, 1'b1, addrOf(0, 0), 8'h41, 7'd1, 5'd0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 12'd0,        8'h00, 7'd2, 5'd0};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 12'd0,        8'h00, 7'd2, 5'd1};
    tbl[4] = '{1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b1, addrOf(2, 1), 8'h42, 7'd3, 5'd1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, addrOf(3, 1), 8'h42, 7'd3, 5'd1};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, addrOf(3, 1), 8'h42, 7'd4, 5'd1};
    tbl[7] = '{1'b1, 8'h43, 1'b1, 1'b1, 1'b0, 1'b1, addrOf(4, 1), 8'h43, 7'd5, 5'd1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 12'd0,        8'h00, 7'd6, 5'd2};
    tbl[9] = '{1'b1, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, addrOf(6, 2), 8'h7E, 7'd7, 5'd2};

    #3;
    doReset();
    for (int i = 0; i < 10; i++) begin
      if (tbl[i].expWe) expQ.push_back('{tbl[i].expAddr, tbl[i].expData});
      applyStimulus(tbl[i].rxTick, tbl[i].rxData, tbl[i].keyRight, tbl[i].keyDown, tbl[i].keyWr, 1'b0);
      checkCursor($sformatf("vec%0d_cur", i), int'(tbl[i].expX), int'(tbl[i].expY));
    end
    checkQueueEmpty("queue_after_table");

    // Right-edge and bottom-right wrap, by keys and by rx.
    doReset();
    moveBy(79, 0);
    checkCursor("cur_at_x79", 79, 0);
    rxWrite(8'h61, 79, 0);
    checkCursor("rx_row_wrap", 0, 1);
    moveBy(79, 28);
    checkCursor("cur_at_79_29", 79, 29);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    checkCursor("key_right_wrap", 0, 29);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    checkCursor("key_down_wrap", 0, 0);
    moveBy(79, 29);
    rxWrite(8'h5A, 79, 29);
    checkCursor("rx_screen_wrap", 0, 0);
    checkQueueEmpty("queue_after_wrap");

    // rx beats key_wr; combined moves.
    doReset();
    rxWrite(8'h41, 0, 0);
    expQ.push_back('{addrOf(1, 0), 8'h42});
    applyStimulus(1'b1, 8'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    checkCursor("rx_over_keywr", 2, 0);
    moveBy(1, 4);
    checkCursor("cur_at_3_4", 3, 4);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCursor("right_down_same_cycle", 4, 5);
    checkQueueEmpty("queue_after_prio");

    // Control bytes.
    doReset();
    moveBy(10, 2);
`ifdef TEXT_CTRL_CHAR_EN
    applyStimulus(1'b1, 8'h0D, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h0A, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCursor("cr_lf", 0, 3);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCursor("bs_saturate", 0, 3);
    moveBy(2, 0);
    applyStimulus(1'b1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0);
    checkCursor("bs_step", 1, 3);
    expQ.push_back('{addrOf(1, 3), 8'h20});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    rxWrite(8'h0D, 10, 2);
    rxWrite(8'h0A, 11, 2);
    checkCursor("cr_lf_glyph", 12, 2);
    expQ.push_back('{addrOf(12, 2), 8'h0A});
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
`endif
    checkQueueEmpty("queue_after_ctrl");

    doReset();
    moveBy(5, 3);
    runClear(1'b0);
    runClear(1'b1);
    doReset();

    // Reset in the middle of a clear must stop the fill for good.
    sbEnable = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    stepIdle(50);
    doReset();
    cnt = wrCount;
    stepIdle(30);
    checkOutput("no_we_after_abort", 32'(wrCount - cnt), 32'd0);
    checkOutput("busy_after_abort", {31'd0, busy}, 32'd0);
    sbEnable = 1'b1;
    rxWrite(8'h55, 0, 0);
    checkQueueEmpty("queue_final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
